// File: rtl/speed_sense.sv
// speed_sense: quadrature encoder speed/direction sensor.
// Counts signed encoder edges over a fixed window of GATE_CYCLES clocks and
// reports the saturated magnitude, the direction and an overflow flag.
//
// Ports:
//   clk    - sole clock, all logic on the rising edge
//   rst    - asynchronous active-high reset
//   en     - measurement enable; low freezes the window and ignores steps
//   enc_a  - quadrature channel A, asynchronous to clk
//   enc_b  - quadrature channel B, asynchronous to clk
//   speed  - |net edges| of the last window, saturated at 255
//   dir    - 1 = forward, 0 = reverse (held when the net count is zero)
//   valid  - one-cycle pulse when speed/dir/ovf update
//   ovf    - |net edges| of the last window exceeded 255
//   err    - one-cycle pulse on an illegal (two-bit) quadrature transition
//
// Optional build macro:
//   SPEED_SENSE_FILTER_EN - glitch filter after the synchronizers; a channel
//                           change is accepted only after 3 identical samples
//                           (pin-to-accumulator latency grows from 3 to 5).

module speed_sense #(
    parameter int GATE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic [7:0] speed,
    output logic       dir,
    output logic       valid,
    output logic       ovf,
    output logic       err
);

    localparam logic [15:0] LAST = 16'(GATE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic a_s1;
    logic a_s2;
    logic b_s1;
    logic b_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= enc_a;
            a_s2 <= a_s1;
            b_s1 <= enc_b;
            b_s2 <= b_s1;
        end
    end

    logic [1:0] sync_ab;
    assign sync_ab = {a_s2, b_s2};

    // ------------------------------------------------------------------
    // Channel state seen by the decoder
    // ------------------------------------------------------------------
    logic [1:0] cur_ab;

`ifdef SPEED_SENSE_FILTER_EN
    // f1/f2 hold the two previous synchronized samples. A channel takes
    // the new value combinationally once the current sample and both
    // history samples agree, so only 2 cycles are added and anything
    // shorter than 3 samples never reaches the decoder.
    logic [1:0] filt_d1;
    logic [1:0] filt_d2;
    logic [1:0] filt_hold;

    always_comb begin
        cur_ab = filt_hold;
        for (int i = 0; i < 2; i++) begin
            if ((sync_ab[i] == filt_d1[i]) &&
                (filt_d1[i] == filt_d2[i])) begin
                cur_ab[i] = sync_ab[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d1   <= 2'b00;
            filt_d2   <= 2'b00;
            filt_hold <= 2'b00;
        end else begin
            filt_d1   <= sync_ab;
            filt_d2   <= filt_d1;
            filt_hold <= cur_ab;
        end
    end
`else
    assign cur_ab = sync_ab;
`endif

    // ------------------------------------------------------------------
    // Previous-state register and transition decoder
    // ------------------------------------------------------------------
    // prev_ab keeps tracking even while en=0 so that re-enabling never
    // sees a stale state and a false step.
    logic [1:0] prev_ab;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab <= 2'b00;
        end else begin
            prev_ab <= cur_ab;
        end
    end

    logic dec_inc;
    logic dec_dec;
    logic dec_ill;

    always_comb begin
        dec_inc = 1'b0;
        dec_dec = 1'b0;
        dec_ill = 1'b0;
        case ({prev_ab, cur_ab})
            // forward: 00 -> 01 -> 11 -> 10 -> 00
            4'b00_01, 4'b01_11,
            4'b11_10, 4'b10_00: dec_inc = 1'b1;
            // reverse: 00 -> 10 -> 11 -> 01 -> 00
            4'b00_10, 4'b10_11,
            4'b11_01, 4'b01_00: dec_dec = 1'b1;
            // both channels moved at once
            4'b00_11, 4'b11_00,
            4'b01_10, 4'b10_01: dec_ill = 1'b1;
            default: ;
        endcase
    end

    // Decode stage register: one cycle between the decoder and the
    // accumulator; err is this stage's illegal flag.
    logic step_inc;
    logic step_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_inc <= 1'b0;
            step_dec <= 1'b0;
            err      <= 1'b0;
        end else begin
            step_inc <= dec_inc;
            step_dec <= dec_dec;
            err      <= dec_ill;
        end
    end

    // ------------------------------------------------------------------
    // Saturating accumulator arithmetic
    // ------------------------------------------------------------------
    logic signed [15:0] acc;
    logic signed [16:0] sum_w;
    logic signed [15:0] net;
    logic        [15:0] net_u;
    logic        [15:0] mag;

    always_comb begin
        sum_w = {acc[15], acc};
        if (step_inc) begin
            sum_w = sum_w + 17'sd1;
        end else if (step_dec) begin
            sum_w = sum_w - 17'sd1;
        end
        if (sum_w > 17'sd32767) begin
            net = 16'sh7fff;
        end else if (sum_w < -17'sd32768) begin
            net = 16'sh8000;
        end else begin
            net = sum_w[15:0];
        end
    end

    // |-32768| = 32768 still fits an unsigned 16-bit magnitude.
    assign net_u = net;
    assign mag   = net_u[15] ? (~net_u + 16'd1) : net_u;

    // ------------------------------------------------------------------
    // Window counter and result registers
    // ------------------------------------------------------------------
    logic [15:0] win_cnt;
    logic        terminal;

    assign terminal = en && (win_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= 16'd0;
            acc     <= 16'sd0;
            speed   <= 8'd0;
            dir     <= 1'b1;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (terminal) begin
                // The step decoded in this cycle closes out this window.
                win_cnt <= 16'd0;
                acc     <= 16'sd0;
                speed   <= (mag > 16'd255) ? 8'hff : mag[7:0];
                ovf     <= (mag > 16'd255);
                valid   <= 1'b1;
                if (net > 16'sd0) begin
                    dir <= 1'b1;
                end else if (net < 16'sd0) begin
                    dir <= 1'b0;
                end
            end else if (en) begin
                win_cnt <= win_cnt + 16'd1;
                acc     <= net;
            end
        end
    end

endmodule

// File: tb/tb_speed_sense.sv
// tb_speed_sense: directed + random bench for speed_sense (GATE_CYCLES=100,
// plus a GATE_CYCLES=300 instance for the saturation case).

`timescale 1ns/1ps

module tb_speed_sense;

    localparam int G  = 100;
    localparam int GL = 300;
`ifdef SPEED_SENSE_FILTER_EN
    localparam int LAT      = 5;
    localparam int HOLD     = 3;
    localparam int FAST_GAP = 2;
`else
    localparam int LAT      = 3;
    localparam int HOLD     = 1;
    localparam int FAST_GAP = 1;
`endif

    localparam logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;
    logic [7:0] speed;
    logic       dir;
    logic       valid;
    logic       ovf;
    logic       err;
    logic [7:0] speed_l;
    logic       dir_l;
    logic       valid_l;
    logic       ovf_l;
    logic       err_l;

    int errors = 0;
    int checks = 0;
    int pos = 0;
    int err_pulses = 0;

    speed_sense #(.GATE_CYCLES(G)) u_dut (
        .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed), .dir(dir), .valid(valid), .ovf(ovf), .err(err)
    );

    speed_sense #(.GATE_CYCLES(GL)) u_long (
        .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed_l), .dir(dir_l), .valid(valid_l), .ovf(ovf_l),
        .err(err_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a pin change seen at clock edge n moves the net
    // count at edge n+LAT; windows close every G enabled edges.
    // ------------------------------------------------------------------
    typedef struct {
        int step;
        bit ill;
    } ev_t;

    ev_t        mq[$];
    logic [1:0] m_prev = 2'b00;
    int         m_acc = 0;
    int         m_win = 0;
    int         m_speed = 0;
    bit         m_dir = 1'b1;
    bit         m_ovf = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_err = 1'b0;

    function automatic int phase(input logic [1:0] v);
        for (int i = 0; i < 4; i++) begin
            if (GRAY[i] == v) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_prev  = 2'b00;
            m_acc   = 0;
            m_win   = 0;
            m_speed = 0;
            m_dir   = 1'b1;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            ev_t        ev;
            ev_t        ap;
            int         d;
            int         mag;
            logic [1:0] cur;
            cur = {enc_a, enc_b};
            d = (phase(cur) - phase(m_prev) + 4) % 4;
            ev.step = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
            ev.ill = (d == 2);
            m_prev = cur;
            mq.push_back(ev);
            ap.step = 0;
            ap.ill = 1'b0;
            if (mq.size() > LAT) ap = mq.pop_front();
            m_err = (mq.size() == LAT) && mq[0].ill;
            m_valid = 1'b0;
            if (en) begin
                m_win++;
                m_acc += ap.step;
                if (m_acc > 32767) m_acc = 32767;
                if (m_acc < -32768) m_acc = -32768;
                if (m_win % G == 0) begin
                    mag = (m_acc < 0) ? -m_acc : m_acc;
                    m_speed = (mag > 255) ? 255 : mag;
                    m_ovf = (mag > 255);
                    if (m_acc > 0) m_dir = 1'b1;
                    else if (m_acc < 0) m_dir = 1'b0;
                    m_acc = 0;
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", valid, m_valid);
            chk("err", err, m_err);
            chk("speed", speed, m_speed);
            chk("dir", dir, m_dir);
            chk("ovf", ovf, m_ovf);
            if (err === 1'b1) err_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_pos();
        logic [1:0] c;
        c = GRAY[((pos % 4) + 4) % 4];
        enc_a = c[1];
        enc_b = c[0];
    endtask

    task automatic move(input int delta, input int gap);
        pos += delta;
        drive_pos();
        tick(gap);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget && cyc == 0; i++) begin
            tick(1);
            if (valid === 1'b1) cyc = i;
        end
        chk("valid_seen", cyc > 0, 1);
    endtask

    task automatic chk_out(input string tag, input int s, input bit d,
                           input bit o);
        chk({tag, "_speed"}, speed, s);
        chk({tag, "_dir"}, dir, d);
        chk({tag, "_ovf"}, ovf, o);
    endtask

    initial begin
        int cyc;
        int e0;
        int exp_l;
        int r;

        // reset held 5 cycles, then static encoder for one window
        rst = 1'b1;
        tick(5);
        chk("rst_speed", speed, 0);
        chk("rst_dir", dir, 1);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        chk("rst_long_speed", speed_l, 0);
        rst = 1'b0;
        wait_valid(3 * G, cyc);
        chk("idle_valid_cycle", cyc, G);
        chk_out("idle", 0, 1'b1, 1'b0);

        // 40 forward steps, one every 2 cycles
        repeat (40) move(1, 2);
        wait_valid(2 * G, cyc);
        chk("fwd40_valid_cycle", cyc, G - 80);
        chk_out("fwd40", 40, 1'b1, 1'b0);

        // 30 reverse steps, then an idle window keeps dir=0
        repeat (30) move(-1, 2);
        wait_valid(2 * G, cyc);
        chk_out("rev30", 30, 1'b0, 1'b0);
        wait_valid(2 * G, cyc);
        chk_out("rev_idle", 0, 1'b0, 1'b0);

        // back to 00, realign on the window boundary
        repeat (2) move(1, 2);
        wait_valid(2 * G, cyc);
        chk_out("realign", 2, 1'b1, 1'b0);

        // illegal jump 00 -> 11
        e0 = err_pulses;
        pos += 2;
        drive_pos();
        tick(10);
        chk("jump_err_pulses", err_pulses - e0, 1);
        wait_valid(2 * G, cyc);
        chk_out("jump", 0, 1'b1, 1'b0);
        repeat (2) move(1, 2);
        wait_valid(2 * G, cyc);

`ifdef SPEED_SENSE_FILTER_EN
        // 2-cycle glitch on enc_a must not count
        e0 = err_pulses;
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(10);
        wait_valid(2 * G, cyc);
        chk_out("glitch", 0, 1'b1, 1'b0);
        chk("glitch_err_pulses", err_pulses - e0, 0);
`endif

        // reset at cycle 50 of a window holding 20 steps
        repeat (20) move(1, 2);
        tick(10);
        rst = 1'b1;
        #1;
        chk("midrst_speed", speed, 0);
        chk("midrst_dir", dir, 1);
        chk("midrst_valid", valid, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_err", err, 0);
        tick(3);
        rst = 1'b0;
        repeat (7) move(1, 2);
        wait_valid(2 * G, cyc);
        chk("midrst_valid_cycle", cyc + 14, G);
        chk_out("midrst", 7, 1'b1, 1'b0);

        // saturation on the 300-cycle instance
        rst = 1'b1;
        pos = 0;
        drive_pos();
        tick(2);
        exp_l = 0;
        for (int i = 1; i <= 700; i++) begin
            if (i % FAST_GAP == 0 && i + LAT > GL && i + LAT <= 2 * GL)
                exp_l++;
        end
        rst = 1'b0;
        for (int i = 1; i <= 700; i++) begin
            if (i % FAST_GAP == 0) begin
                pos++;
                drive_pos();
            end
            tick(1);
            if (i == GL) chk("long_w1_valid", valid_l, 1);
            if (i == 2 * GL) begin
                chk("long_w2_valid", valid_l, 1);
                chk("long_w2_speed", speed_l, (exp_l > 255) ? 255 : exp_l);
                chk("long_w2_ovf", ovf_l, exp_l > 255);
                chk("long_w2_dir", dir_l, 1);
            end
        end

        // random walk with illegal jumps and enable gaps
        for (int i = 0; i < 900; i++) begin
            if (i % HOLD == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4) pos++;
                else if (r < 7) pos--;
                else if (r == 7) pos += 2;
                drive_pos();
            end
            if ($urandom_range(0, 24) == 0) en = ~en;
            tick(1);
        end
        en = 1'b1;
        tick(2 * G + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
